uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Serial UART receiver (8N1) that recovers bytes from the asynchronous `rx` line and presents each one as `uart_data` with a single-cycle `new_data` strobe. It sits directly upstream of `store_configs`, whose `uart_data`/`new_data` inputs it drives, and is the only path by which host configuration bytes enter the FPGA. It also reports framing errors so the config stage or top level can flag a corrupted download.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Legal range 8..65535.
- `CNT_W`, default 16: width of the bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (`rst`=0 resets).
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `uart_data`  out  8  last correctly framed byte, LSB received first; held until the next good byte.
- `new_data`  out  1  one-cycle strobe; `uart_data` is valid in the same cycle.
- `frame_err`  out  1  one-cycle strobe; stop bit was sampled low.
- `rx_busy`  out  1  high from start-bit detection until return to IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. `rx_s` below means the synchronized value.
- State machine:
  - IDLE: wait for `rx_s` = 0, then go to START and clear the counter.
  - START: at count `CLKS_PER_BIT/2 - 1` (integer division), sample `rx_s`. If it is 1, the low level was a glitch: go back to IDLE with no strobe. If it is 0, go to DATA and clear the counter and the bit index.
  - DATA: at count `CLKS_PER_BIT-1`, sample `rx_s` into shift register bit `[idx]`. Increment idx; after idx = 7, go to STOP.
  - STOP: at count `CLKS_PER_BIT-1`, sample `rx_s`.
    - If it is 1, load `uart_data` from the shift register, pulse `new_data`, and go to IDLE.
    - If it is 0, pulse `frame_err`, leave `uart_data` unchanged, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then go to IDLE. This stops a break condition from producing repeated frames.
- `new_data` and `frame_err` are never high in the same cycle, and each is never high for two consecutive cycles.
- The counter saturates nowhere; it is cleared on every sample point and on every state change.
- Reset values: state IDLE, `uart_data` = 8'h00, `new_data` = 0, `frame_err` = 0, `rx_busy` = 0, counter = 0, idx = 0, shift register = 0.
- Reset asserted mid-frame aborts the frame immediately with no strobe. After reset is released, reception restarts at the next falling edge; a line that is already low waits in IDLE only until START confirms it.
- No output FIFO. `store_configs` consumes every strobe in the cycle it occurs, so no back-pressure exists.

## Timing
- Let cycle 0 be the first cycle in which `rx_s` = 0; this is 2 cycles after `rx` falls.
- Start sample: cycle `CLKS_PER_BIT/2`.
- Data bit k is sampled at cycle `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
- Stop sample: cycle `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`. `new_data`/`frame_err` are registered and assert in the following cycle.
- Back-to-back frames: IDLE is re-entered about half a bit before the nominal end of the stop bit, so a start bit arriving immediately after the stop bit is caught. Tolerated baud mismatch is ±4%.
- `rx_busy` rises the cycle after START is entered and falls the cycle IDLE is re-entered.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP, WAIT_IDLE, 3 bits);
  - `UART_CLKS_PER_BIT_DEFAULT` = 868;
  - `UART_DATA_W` = 8.
- One sub-module, `sync_2ff` (1-bit, reset value parameter), for the `rx` synchronizer; it is reused for other asynchronous inputs.
- Everything else is a single always block for the FSM and counters, plus a registered output stage.

## Test plan
All directed tests run with `CLKS_PER_BIT` = 16.
- Send byte 0xA5 with a correct stop bit -> exactly one `new_data` pulse, `uart_data` = 8'hA5 at 2 + 8 + 144 + 1 cycles after `rx` falls; `frame_err` stays 0.
- Send bytes 0x01, 0xFF, 0x80 back-to-back with no idle gap -> three `new_data` pulses carrying 0x01, 0xFF, 0x80 in order, each 160 cycles apart.
- Pulse `rx` low for 5 cycles only -> returns to IDLE, no strobe, `uart_data` unchanged, `rx_busy` drops by cycle 10.
- Send 0x3C with the stop bit held low, then hold `rx` low for 40 more cycles -> one `frame_err` pulse, no `new_data`, `uart_data` keeps its previous value. Once `rx` rises, a following 0x55 frame is received correctly.
- Assert `rst` low in the middle of data bit 4 of a frame -> all outputs 0 immediately and no strobe for that frame. After release, a fresh 0x7E frame produces `uart_data` = 8'h7E.
- Send 0xC3 at ±3% bit period -> received correctly both times.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive path: receiver
//                state encoding, default bit timing and data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // 100 MHz system clock / 115200 baud
   localparam int UART_CLKS_PER_BIT_DEFAULT = 868;
   localparam int UART_DATA_W               = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous input.
//                Both flops load RESET_VAL while rst is low so the output
//                starts at the line's idle level.
//  Ports       : clk  - destination clock
//                rst  - asynchronous reset, active low
//                d    - asynchronous input
//                q    - synchronized output
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_rx
//  Description : 8N1 UART receiver. Recovers bytes from the asynchronous rx
//                line and presents each good byte with a one-cycle strobe;
//                a low stop bit gives a one-cycle framing-error strobe.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous reset, active low
//                rx         - raw serial line, idle high
//                uart_data  - last correctly framed byte (held)
//                new_data   - one-cycle strobe, uart_data valid same cycle
//                frame_err  - one-cycle strobe, stop bit sampled low
//                rx_busy    - high while a frame is being received
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int CNT_W        = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   output logic [UART_DATA_W-1:0] uart_data,
   output logic                   new_data,
   output logic                   frame_err,
   output logic                   rx_busy
);

   localparam logic [CNT_W-1:0] c_half_m1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] c_full_m1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

   logic                   w_rx_s;

   uart_state_t            r_state,  w_state_nxt;
   logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
   logic [2:0]             r_idx,    w_idx_nxt;
   logic [UART_DATA_W-1:0] r_shift,  w_shift_nxt;
   logic [UART_DATA_W-1:0] r_data,   w_data_nxt;
   logic                   r_new,    w_new_nxt;
   logic                   r_ferr,   w_ferr_nxt;
   logic                   r_busy,   w_busy_nxt;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (w_rx_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_new   <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_new   <= w_new_nxt;
         r_ferr  <= w_ferr_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + c_one;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_new_nxt   = 1'b0;
      w_ferr_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // Counter is parked at zero so START begins timing from 0.
            w_cnt_nxt = '0;
            if (!w_rx_s) begin
               w_state_nxt = ST_START;
            end
         end

         ST_START: begin
            // Mid-bit check rejects short low glitches.
            if (r_cnt == c_half_m1) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
            end
         end

         ST_DATA: begin
            if (r_cnt == c_full_m1) begin
               w_cnt_nxt          = '0;
               w_shift_nxt[r_idx] = w_rx_s;
               w_idx_nxt          = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
                  w_state_nxt = ST_STOP;
               end
            end
         end

         ST_STOP: begin
            // Leaving at mid stop bit gives half a bit of slack to catch
            // a start bit that immediately follows.
            if (r_cnt == c_full_m1) begin
               w_cnt_nxt = '0;
               if (w_rx_s) begin
                  w_data_nxt  = r_shift;
                  w_new_nxt   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = ST_WAIT_IDLE;
               end
            end
         end

         ST_WAIT_IDLE: begin
            // A held-low (break) line must go high before a new frame.
            w_cnt_nxt = '0;
            if (w_rx_s) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Busy rises one cycle after START is entered and drops in the same
      // cycle the state register returns to IDLE.
      w_busy_nxt = (r_state != ST_IDLE) && (w_state_nxt != ST_IDLE);
   end

   assign uart_data = r_data;
   assign new_data  = r_new;
   assign frame_err = r_ferr;
   assign rx_busy   = r_busy;

endmodule : uart_byte_rx
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_byte_rx
//  Description : Self-checking bench for uart_byte_rx at 16 clocks per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_rx;

   localparam int  CPB    = 16;
   localparam real CLK_NS = 10.0;
   localparam real BIT_NS = CPB * CLK_NS;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] uart_data;
   logic       new_data;
   logic       frame_err;
   logic       rx_busy;

   uart_byte_rx #(
      .CLKS_PER_BIT (CPB),
      .CNT_W        (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .uart_data (uart_data),
      .new_data  (new_data),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- output monitor ----------------
   typedef struct {
      int         cyc;
      logic [7:0] d;
   } evt_t;

   evt_t got_q[$];
   evt_t mon_e;
   int   nd_cnt   = 0;
   int   fe_cnt   = 0;
   int   viol_cnt = 0;
   logic prev_nd  = 1'b0;
   logic prev_fe  = 1'b0;

   always @(negedge clk) begin
      if (new_data === 1'b1) begin
         mon_e.cyc = cyc;
         mon_e.d   = uart_data;
         got_q.push_back(mon_e);
         nd_cnt++;
      end
      if (frame_err === 1'b1) fe_cnt++;
      if ((new_data && frame_err) || (new_data && prev_nd) || (frame_err && prev_fe))
         viol_cnt++;
      prev_nd = new_data;
      prev_fe = frame_err;
   end

   // ---------------- checking helpers ----------------
   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   int         fall_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drain(input string name);
      evt_t e;
      while (got_q.size() > 0) begin
         e = got_q.pop_front();
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got byte 0x%0h, expected no byte", name, e.d);
         end else begin
            check(name, {24'h0, e.d}, {24'h0, exp_q.pop_front()});
         end
      end
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves rx at the stop-bit level on return.
   task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns,
                             input logic expect_byte);
      if (expect_byte) exp_q.push_back(b);
      rx       = 1'b0;
      fall_cyc = cyc;
      #(bit_ns);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         #(bit_ns);
      end
      rx = stop;
      #(bit_ns);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      logic       stop;
      real        bit_ns;
      logic [7:0] exp_data;
      int         exp_nd;
      int         exp_fe;
   } vec_t;

   function automatic vec_t mk_vec(input logic [7:0] d, input logic s, input real bn,
                                   input logic [7:0] ed, input int en, input int ef);
      vec_t v;
      v.data = d; v.stop = s; v.bit_ns = bn;
      v.exp_data = ed; v.exp_nd = en; v.exp_fe = ef;
      return v;
   endfunction

   localparam int NVEC = 7;
   vec_t vecs[NVEC];

   initial begin
      int nd0, fe0, f0;

      vecs[0] = mk_vec(8'hA5, 1'b1, BIT_NS,        8'hA5, 1, 0);
      vecs[1] = mk_vec(8'h00, 1'b1, BIT_NS,        8'h00, 1, 0);
      vecs[2] = mk_vec(8'hFF, 1'b1, BIT_NS,        8'hFF, 1, 0);
      vecs[3] = mk_vec(8'h3C, 1'b0, BIT_NS,        8'hFF, 0, 1);
      vecs[4] = mk_vec(8'h55, 1'b1, BIT_NS,        8'h55, 1, 0);
      vecs[5] = mk_vec(8'hC3, 1'b1, BIT_NS * 1.03, 8'hC3, 1, 0);
      vecs[6] = mk_vec(8'hC3, 1'b1, BIT_NS * 0.97, 8'hC3, 1, 0);

      // ---- reset state ----
      idle(3);
      check("reset uart_data", {24'h0, uart_data}, 32'h0);
      check("reset new_data",  {31'h0, new_data},  32'h0);
      check("reset frame_err", {31'h0, frame_err}, 32'h0);
      check("reset rx_busy",   {31'h0, rx_busy},   32'h0);
      rst = 1'b1;
      idle(5);

      // ---- table-driven single frames ----
      for (int i = 0; i < NVEC; i++) begin
         nd0 = nd_cnt;
         fe0 = fe_cnt;
         align();
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_ns, vecs[i].stop);
         rx = 1'b1;
         idle(3 * CPB);
         check($sformatf("vec%0d new_data count", i), nd_cnt - nd0, vecs[i].exp_nd);
         check($sformatf("vec%0d frame_err count", i), fe_cnt - fe0, vecs[i].exp_fe);
         check($sformatf("vec%0d uart_data", i), {24'h0, uart_data}, {24'h0, vecs[i].exp_data});
         if (vecs[i].exp_nd == 1 && vecs[i].bit_ns == BIT_NS && got_q.size() > 0)
            check($sformatf("vec%0d strobe latency", i), got_q[0].cyc - fall_cyc, 155);
         drain($sformatf("vec%0d scoreboard", i));
      end

      // ---- back-to-back frames, no idle gap ----
      nd0 = nd_cnt;
      align();
      send_frame(8'h01, 1'b1, BIT_NS, 1'b1);
      f0 = fall_cyc;
      send_frame(8'hFF, 1'b1, BIT_NS, 1'b1);
      send_frame(8'h80, 1'b1, BIT_NS, 1'b1);
      idle(3 * CPB);
      check("b2b new_data count", nd_cnt - nd0, 3);
      if (got_q.size() >= 3) begin
         check("b2b first latency", got_q[0].cyc - f0, 155);
         check("b2b spacing 1-2", got_q[1].cyc - got_q[0].cyc, 160);
         check("b2b spacing 2-3", got_q[2].cyc - got_q[1].cyc, 160);
      end
      drain("b2b scoreboard");

      // ---- stop bit low, then break held low ----
      nd0 = nd_cnt;
      fe0 = fe_cnt;
      align();
      send_frame(8'h3C, 1'b0, BIT_NS, 1'b0);
      #(40 * CLK_NS);
      check("break frame_err count", fe_cnt - fe0, 1);
      check("break new_data count", nd_cnt - nd0, 0);
      check("break uart_data kept", {24'h0, uart_data}, 32'h80);
      check("break rx_busy held", {31'h0, rx_busy}, 32'h1);
      rx = 1'b1;
      idle(4);
      check("break rx_busy released", {31'h0, rx_busy}, 32'h0);
      align();
      send_frame(8'h55, 1'b1, BIT_NS, 1'b1);
      idle(3 * CPB);
      check("after break uart_data", {24'h0, uart_data}, 32'h55);
      check("after break frame_err count", fe_cnt - fe0, 1);
      drain("after break scoreboard");

      // ---- 5-cycle glitch ----
      nd0 = nd_cnt;
      fe0 = fe_cnt;
      align();
      rx = 1'b0;
      #(5 * CLK_NS);
      check("glitch rx_busy during", {31'h0, rx_busy}, 32'h1);
      rx = 1'b1;
      idle(9);
      check("glitch rx_busy dropped", {31'h0, rx_busy}, 32'h0);
      idle(2 * CPB);
      check("glitch new_data count", nd_cnt - nd0, 0);
      check("glitch frame_err count", fe_cnt - fe0, 0);
      check("glitch uart_data kept", {24'h0, uart_data}, 32'h55);

      // ---- reset in the middle of data bit 4 ----
      nd0 = nd_cnt;
      fe0 = fe_cnt;
      align();
      begin
         logic [7:0] b;
         b  = 8'h96;
         rx = 1'b0;
         #(BIT_NS);
         for (int k = 0; k < 4; k++) begin
            rx = b[k];
            #(BIT_NS);
         end
         rx = b[4];
         #(BIT_NS / 2);
      end
      check("pre-reset rx_busy", {31'h0, rx_busy}, 32'h1);
      rst = 1'b0;
      #1;
      check("mid reset uart_data", {24'h0, uart_data}, 32'h0);
      check("mid reset rx_busy",   {31'h0, rx_busy},   32'h0);
      check("mid reset new_data",  {31'h0, new_data},  32'h0);
      check("mid reset frame_err", {31'h0, frame_err}, 32'h0);
      rx = 1'b1;
      idle(5);
      rst = 1'b1;
      idle(10 * CPB);
      check("aborted frame new_data count", nd_cnt - nd0, 0);
      check("aborted frame frame_err count", fe_cnt - fe0, 0);
      align();
      send_frame(8'h7E, 1'b1, BIT_NS, 1'b1);
      idle(3 * CPB);
      check("post reset uart_data", {24'h0, uart_data}, 32'h7E);
      check("post reset new_data count", nd_cnt - nd0, 1);
      drain("post reset scoreboard");

      // ---- global invariants ----
      check("strobe overlap/repeat violations", viol_cnt, 0);
      check("scoreboard leftover expected", exp_q.size(), 0);
      check("scoreboard leftover received", got_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_uart_byte_rx
`default_nettype wire
